// File: rtl/mips_div_pkg.sv
// mips_div_pkg: shared state encoding and counter sizing for the MIPS divide unit
package mips_div_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } div_state_t;

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/mips_div_unit_step.sv
// div_step: one restoring shift-subtract-select step over a (WIDTH+1)-bit partial remainder
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_nxt,
    output logic [WIDTH-1:0] quo_nxt
);

    logic [WIDTH:0] sh;
    logic [WIDTH:0] trial;
    logic           borrow;

    // shift the next dividend bit in, trial-subtract, keep or restore
    always_comb begin
        sh      = {rem[WIDTH-1:0], quo[WIDTH-1]};
        trial   = sh - {1'b0, divisor};
        borrow  = trial[WIDTH] & ~rem[WIDTH];
        rem_nxt = borrow ? sh : trial;
        quo_nxt = {quo[WIDTH-2:0], ~borrow};
    end

endmodule

// File: rtl/mips_div_unit.sv
// mips_div_unit: multi-cycle restoring DIV/DIVU; optional DIV_EARLY_OUT_EN skips the bit loop for trivial cases
module mips_div_unit
    import mips_div_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = cnt_w(WIDTH);

    div_state_t       state;
    logic [WIDTH:0]   rem;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] dsr;
    logic [CW-1:0]    cnt;
    logic             q_neg;
    logic             r_neg;
    logic             dz;
    logic [WIDTH:0]   rem_nxt;
    logic [WIDTH-1:0] quo_nxt;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             b_zero;
    logic             early;

    // operand signs and magnitudes; DIVU treats both as non-negative
    always_comb begin
        a_neg  = signed_op & dividend[WIDTH-1];
        b_neg  = signed_op & divisor[WIDTH-1];
        a_mag  = a_neg ? -dividend : dividend;
        b_mag  = b_neg ? -divisor : divisor;
        b_zero = divisor == '0;
    end

`ifdef DIV_EARLY_OUT_EN
    assign early = b_zero || (a_mag < b_mag);
`else
    assign early = 1'b0;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem     (rem),
        .quo     (quo),
        .divisor (dsr),
        .rem_nxt (rem_nxt),
        .quo_nxt (quo_nxt)
    );

    // control FSM and datapath; early-out preloads the loop's final values and enters FIX so signs still apply
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            rem         <= '0;
            quo         <= '0;
            dsr         <= '0;
            cnt         <= '0;
            q_neg       <= 1'b0;
            r_neg       <= 1'b0;
            dz          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: if (start) begin
                    dsr   <= b_mag;
                    q_neg <= a_neg ^ b_neg;
                    r_neg <= a_neg;
                    dz    <= b_zero;
                    cnt   <= '0;
                    busy  <= 1'b1;
                    rem   <= early ? {1'b0, a_mag} : '0;
                    quo   <= early ? (b_zero ? '1 : '0) : a_mag;
                    state <= early ? S_FIX : S_CALC;
                end
                S_CALC: begin
                    rem   <= rem_nxt;
                    quo   <= quo_nxt;
                    cnt   <= cnt + 1'b1;
                    state <= (cnt == CW'(WIDTH - 1)) ? S_FIX : S_CALC;
                end
                S_FIX: begin
                    quo   <= q_neg ? -quo : quo;
                    rem   <= r_neg ? {1'b0, -rem[WIDTH-1:0]} : rem;
                    busy  <= 1'b0;
                    state <= S_DONE;
                end
                S_DONE: begin
                    quotient    <= quo;
                    remainder   <= rem[WIDTH-1:0];
                    div_by_zero <= dz;
                    done        <= 1'b1;
                    state       <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_div_unit.sv
// tb_mips_div_unit: directed and random DIV/DIVU checks against an arithmetic reference model
module tb_mips_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         signed_op;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    int checks = 0;
    int errors = 0;

    mips_div_unit #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_op   (signed_op),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // MIPS semantics: magnitude divide, quotient sign = xor of signs, remainder sign = dividend sign
    function automatic void model(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
        logic         an, bn;
        logic [W-1:0] am, bm, qm, rm;
        an = sop & a[W-1];
        bn = sop & b[W-1];
        am = an ? -a : a;
        bm = bn ? -b : b;
        z  = (b == 0);
        if (z) begin
            qm = '1;
            rm = am;
        end else begin
            qm = am / bm;
            rm = am % bm;
        end
        q = (an ^ bn) ? -qm : qm;
        r = an ? -rm : rm;
    endfunction

    function automatic int exp_lat(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef DIV_EARLY_OUT_EN
        logic [W-1:0] am, bm;
        am = (sop & a[W-1]) ? -a : a;
        bm = (sop & b[W-1]) ? -b : b;
        return (b == 0 || am < bm) ? 2 : W + 2;
`else
        return W + 2;
`endif
    endfunction

    task automatic do_op(input logic sop, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
        logic [W-1:0] eq, er, cq, cr;
        logic         ez, cz;
        int           lat, nb, nd, el;
        model(sop, a, b, eq, er, ez);
        el = exp_lat(sop, a, b);
        @(negedge clk);
        start = 1'b1; signed_op = sop; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0;
        nb = busy ? 1 : 0; nd = 0; lat = 0; cq = '0; cr = '0; cz = 1'b0;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (busy) nb++;
            if (done) begin
                nd++;
                if (lat == 0) begin
                    lat = i; cq = quotient; cr = remainder; cz = div_by_zero;
                end
            end
        end
        chk({tag, ".lat"}, W'(lat), W'(el));
        chk({tag, ".busy_cycles"}, W'(nb), W'(el - 1));
        chk({tag, ".done_pulses"}, W'(nd), W'(1));
        chk({tag, ".q"}, cq, eq);
        chk({tag, ".r"}, cr, er);
        chk({tag, ".dz"}, W'(cz), W'(ez));
        chk({tag, ".q_held"}, quotient, eq);
    endtask

    initial begin
        logic [W-1:0] eq, er, b;
        logic         ez;
        int           nd, nb;
        rst = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.q", quotient, '0);
        chk("rst.r", remainder, '0);
        chk("rst.busy", W'(busy), '0);
        chk("rst.done", W'(done), '0);
        chk("rst.dz", W'(div_by_zero), '0);
        @(negedge clk) rst = 1'b0;

        do_op(1'b0, 32'd100, 32'd7, "divu_100_7");
        do_op(1'b1, -32'sd7, 32'd2, "div_m7_2");
        do_op(1'b1, 32'd7, -32'sd2, "div_7_m2");
        do_op(1'b0, 32'd5, 32'd0, "divu_5_0");
        do_op(1'b0, 32'd20, 32'd6, "divu_clear_dz");
        do_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
        do_op(1'b1, -32'sd5, 32'd0, "div_m5_0");
        do_op(1'b0, 32'd3, 32'd9, "divu_3_9");
        do_op(1'b0, 32'hFFFF_FFFF, 32'd1, "divu_max_1");

        // extra starts mid-operation and during DONE must be ignored
        model(1'b0, 32'd1000, 32'd7, eq, er, ez);
        @(negedge clk);
        start = 1'b1; signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd7;
        @(posedge clk); #1;
        start = 1'b0; nd = 0; nb = busy ? 1 : 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 5 || i == 20 || i == W + 2) begin
                start = 1'b1; dividend = 32'd9; divisor = 32'd3;
            end
            @(posedge clk); #1;
            start = 1'b0;
            if (busy) nb++;
            if (done) nd++;
        end
        chk("restart.done_pulses", W'(nd), W'(1));
        chk("restart.busy_cycles", W'(nb), W'(W + 1));
        chk("restart.q", quotient, eq);
        chk("restart.r", remainder, er);

        // reset mid-CALC drops the operation
        @(negedge clk);
        start = 1'b1; signed_op = 1'b0; dividend = 32'd1000; divisor = 32'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        chk("midrst.q", quotient, '0);
        chk("midrst.r", remainder, '0);
        chk("midrst.busy", W'(busy), '0);
        chk("midrst.done", W'(done), '0);
        @(negedge clk) rst = 1'b0;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) nd++;
        end
        chk("midrst.no_activity", W'(nd), '0);
        do_op(1'b0, 32'd1000, 32'd3, "after_rst");

        for (int k = 0; k < 24; k++) begin
            case ($urandom_range(0, 3))
                0: b = '0;
                1: b = W'($urandom_range(1, 300));
                2: b = -W'($urandom_range(1, 300));
                default: b = W'($urandom);
            endcase
            do_op(1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 500)) : W'($urandom),
                  b, $sformatf("rand%0d", k));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
